// File: rtl/nios_key_pio_irq.sv
// Avalon-MM key PIO with edge capture, W1C clear, irq mask and registered level irq.
// Optional per-bit debounce filter: define NIOS_KEY_PIO_DEBOUNCE_EN.

`ifdef NIOS_KEY_PIO_DEBOUNCE_EN
module nios_key_pio_debounce #(
  parameter int unsigned CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync,
  output logic filt
);
  localparam int CW = $clog2(CYCLES + 1);
  logic [CW-1:0] cnt;

  // cnt never exceeds CYCLES-1; it restarts whenever sync agrees with filt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      filt <= 1'b1;
    end else if (sync == filt) begin
      cnt  <= '0;
    end else if (cnt == CW'(CYCLES - 1)) begin
      cnt  <= '0;
      filt <= sync;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end
endmodule
`endif

module nios_key_pio_irq #(
  parameter int WIDTH           = 4,
  parameter int EDGE_MODE       = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] sync_q1, sync_q2;
  logic [WIDTH-1:0] filt, filt_d, edge_det;
  logic [WIDTH-1:0] irqmask, edgecapture, clr;
  logic [31:0]      rd_next;
  logic             wr;
  logic             unused_wd;

  assign unused_wd = ^writedata;

  // Keys idle high, so the synchronizer resets to ones to avoid a phantom edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= in_port;
      sync_q2 <= sync_q1;
    end
  end

`ifdef NIOS_KEY_PIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    nios_key_pio_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .sync    (sync_q2[i]),
      .filt    (filt[i])
    );
  end
`else
  localparam int unused_dbc = DEBOUNCE_CYCLES;
  assign filt = sync_q2;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) filt_d <= '1;
    else          filt_d <= filt;
  end

  if (EDGE_MODE == 0) begin : g_rise
    assign edge_det = filt & ~filt_d;
  end else if (EDGE_MODE == 1) begin : g_fall
    assign edge_det = ~filt & filt_d;
  end else begin : g_any
    assign edge_det = filt ^ filt_d;
  end

  assign wr  = chipselect && !write_n;
  assign clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_next = '0;
    case (address)
      2'd0:    rd_next = 32'(filt);
      2'd2:    rd_next = 32'(irqmask);
      2'd3:    rd_next = 32'(edgecapture);
      default: rd_next = '0;
    endcase
  end

  // A new edge wins over a same-cycle W1C clear of that bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask     <= '0;
      edgecapture <= '0;
      readdata    <= '0;
      irq         <= 1'b0;
    end else begin
      if (wr && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
      edgecapture <= (edgecapture & ~clr) | edge_det;
      readdata    <= rd_next;
      irq         <= |(edgecapture & irqmask);
    end
  end
endmodule

// File: tb/tb_nios_key_pio_irq.sv
// Directed vector table plus hand sequences for nios_key_pio_irq (WIDTH=4, falling edge).
module tb_nios_key_pio_irq;
`ifdef NIOS_KEY_PIO_DEBOUNCE_EN
  localparam int L = 8;
`else
  localparam int L = 0;
`endif

  logic        clk = 0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nios_key_pio_irq #(.WIDTH(4), .EDGE_MODE(1), .DEBOUNCE_CYCLES(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  typedef struct {
    logic [3:0]  in;
    logic [1:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    int          cyc;
    logic        chk_rd;
    logic [31:0] rd;
    logic        irq;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic bus(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    address = a; chipselect = cs; write_n = wn; writedata = wd;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{4'hF, 2'd0, 1'b0, 1'b1, 32'h0,        3,     1'b1, 32'hF, 1'b0};
    vecs[1]  = '{4'hF, 2'd3, 1'b0, 1'b1, 32'h0,        1,     1'b1, 32'h0, 1'b0};
    vecs[2]  = '{4'hF, 2'd2, 1'b0, 1'b1, 32'h0,        1,     1'b1, 32'h0, 1'b0};
    vecs[3]  = '{4'hF, 2'd1, 1'b0, 1'b1, 32'h0,        1,     1'b1, 32'h0, 1'b0};
    vecs[4]  = '{4'hF, 2'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 1,     1'b0, 32'h0, 1'b0};
    vecs[5]  = '{4'hF, 2'd1, 1'b0, 1'b1, 32'h0,        1,     1'b1, 32'h0, 1'b0};
    vecs[6]  = '{4'hF, 2'd2, 1'b1, 1'b0, 32'hFFFFFFF1, 1,     1'b0, 32'h0, 1'b0};
    vecs[7]  = '{4'hF, 2'd2, 1'b0, 1'b1, 32'h0,        1,     1'b1, 32'h1, 1'b0};
    vecs[8]  = '{4'hF, 2'd2, 1'b0, 1'b0, 32'hF,        1,     1'b0, 32'h0, 1'b0};
    vecs[9]  = '{4'hF, 2'd2, 1'b0, 1'b1, 32'h0,        1,     1'b1, 32'h1, 1'b0};
    vecs[10] = '{4'hE, 2'd0, 1'b0, 1'b1, 32'h0,        3 + L, 1'b1, 32'hE, 1'b0};
    vecs[11] = '{4'hE, 2'd3, 1'b0, 1'b1, 32'h0,        1,     1'b1, 32'h1, 1'b1};
    vecs[12] = '{4'hE, 2'd3, 1'b1, 1'b0, 32'h1,        1,     1'b0, 32'h0, 1'b1};
    vecs[13] = '{4'hE, 2'd3, 1'b0, 1'b1, 32'h0,        1,     1'b1, 32'h0, 1'b0};
    vecs[14] = '{4'hE, 2'd2, 1'b1, 1'b0, 32'h0,        1,     1'b0, 32'h0, 1'b0};
    vecs[15] = '{4'hA, 2'd3, 1'b0, 1'b1, 32'h0,        4 + L, 1'b1, 32'h4, 1'b0};
    vecs[16] = '{4'hA, 2'd2, 1'b1, 1'b0, 32'h4,        1,     1'b0, 32'h0, 1'b0};
    vecs[17] = '{4'hA, 2'd3, 1'b0, 1'b1, 32'h0,        1,     1'b1, 32'h4, 1'b1};
    vecs[18] = '{4'hF, 2'd0, 1'b0, 1'b1, 32'h0,        4 + L, 1'b1, 32'hF, 1'b1};
    vecs[19] = '{4'hF, 2'd3, 1'b1, 1'b0, 32'h0,        1,     1'b0, 32'h0, 1'b1};
    vecs[20] = '{4'hF, 2'd3, 1'b0, 1'b1, 32'h0,        1,     1'b1, 32'h4, 1'b1};
    vecs[21] = '{4'hF, 2'd3, 1'b1, 1'b0, 32'h4,        1,     1'b0, 32'h0, 1'b1};
    vecs[22] = '{4'hF, 2'd3, 1'b0, 1'b1, 32'h0,        2,     1'b1, 32'h0, 1'b0};

    reset_n = 0;
    in_port = 4'hF;
    bus(2'd0, 1'b0, 1'b1, 32'h0);
    tick(3);
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    reset_n = 1;

    for (int i = 0; i < 23; i++) begin
      in_port = vecs[i].in;
      bus(vecs[i].addr, vecs[i].cs, vecs[i].wn, vecs[i].wd);
      tick(vecs[i].cyc);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_readdata", i), readdata, vecs[i].rd);
      chk($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].irq});
    end

    // Same-cycle edge and W1C clear on bit1: the set must win
    in_port = 4'hD;
    bus(2'd3, 1'b0, 1'b1, 32'h0);
    tick(4 + L);
    chk("key1_first_capture", readdata, 32'h2);
    in_port = 4'hF;
    tick(4 + L);
    in_port = 4'hD;
    tick(2 + L);
    bus(2'd3, 1'b1, 1'b0, 32'h2);
    tick(1);
    bus(2'd3, 1'b0, 1'b1, 32'h0);
    tick(1);
    chk("set_beats_clear", readdata, 32'h2);
    in_port = 4'hF;
    tick(3 + L);
    bus(2'd3, 1'b1, 1'b0, 32'h2);
    tick(1);
    bus(2'd3, 1'b0, 1'b1, 32'h0);
    tick(1);
    chk("clear_after_release", readdata, 32'h0);

`ifdef NIOS_KEY_PIO_DEBOUNCE_EN
    // 5-clk glitch is shorter than the 8-clk debounce window
    bus(2'd0, 1'b0, 1'b1, 32'h0);
    in_port = 4'hE;
    tick(5);
    in_port = 4'hF;
    tick(12);
    chk("glitch_filt", readdata, 32'hF);
    bus(2'd3, 1'b0, 1'b1, 32'h0);
    tick(1);
    chk("glitch_edgecapture", readdata, 32'h0);
    bus(2'd0, 1'b0, 1'b1, 32'h0);
    in_port = 4'hE;
    tick(10);
    chk("stable_not_early", readdata, 32'hF);
    tick(1);
    chk("stable_filt", readdata, 32'hE);
    bus(2'd3, 1'b0, 1'b1, 32'h0);
    tick(1);
    chk("stable_edgecapture", readdata, 32'h1);
`endif

    // Reset mid-debounce with key0 low, then keys released during reset
    bus(2'd2, 1'b1, 1'b0, 32'hF);
    tick(1);
    bus(2'd3, 1'b0, 1'b1, 32'h0);
    in_port = 4'hE;
    tick(4);
    reset_n = 0;
    #2;
    chk("midreset_readdata", readdata, 32'h0);
    chk("midreset_irq", {31'h0, irq}, 32'h0);
    in_port = 4'hF;
    tick(1);
    reset_n = 1;
    tick(10 + L);
    chk("post_reset_edgecapture", readdata, 32'h0);
    chk("post_reset_irq", {31'h0, irq}, 32'h0);
    bus(2'd2, 1'b0, 1'b1, 32'h0);
    tick(1);
    chk("post_reset_irqmask", readdata, 32'h0);
    bus(2'd0, 1'b0, 1'b1, 32'h0);
    tick(1);
    chk("post_reset_data", readdata, 32'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
